cdb_arbiter: RTL
================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_FU, default 9: number of requesting functional units; index 5 is the jump unit.
REQ-002 Parameter DATA_W, default 32: result width.
REQ-003 Parameter TAG_W, default 5: reservation-station tag width.
REQ-004 The module SHALL have exactly these ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- finish  input  NUM_FU  per-FU result-ready request, held until granted.
- fu_data  input  NUM_FU*DATA_W  per-FU result, FU i at bits [i*DATA_W +: DATA_W].
- fu_tag  input  NUM_FU*TAG_W  per-FU producing tag, packed the same way.
- flush  input  1  synchronous squash of the in-flight broadcast.
- CDB_result  output  NUM_FU  registered one-hot grant/acknowledge to the FUs.
- cdb_valid  output  1  broadcast valid.
- cdb_data  output  DATA_W  broadcast result.
- cdb_tag  output  TAG_W  broadcast tag.

Function
REQ-005 At most one CDB_result bit SHALL be high in any cycle; cdb_valid SHALL equal the OR of CDB_result.
REQ-006 Eligible set at each edge SHALL be finish AND NOT CDB_result (current grant).
- Reason: the granted FU drops finish only at the edge after it sees its grant.
REQ-007 Arbitration SHALL be round-robin.
- Pointer last holds the index of the last granted FU.
- Search starts at last+1 and wraps from NUM_FU-1 to 0.
- The first eligible index wins.
REQ-008 On a win, at the same edge:
- CDB_result is set to the winner's one-hot bit.
- cdb_data and cdb_tag capture that FU's fu_data and fu_tag.
- last is updated to the winner's index.
REQ-009 Latency SHALL be one cycle: finish high before edge k with the FU eligible -> grant and broadcast visible during the cycle after edge k.
REQ-010 With an empty eligible set:
- CDB_result clears to 0 and cdb_valid clears to 0.
- cdb_data and cdb_tag hold their last values.
- last holds.
REQ-011 Each grant SHALL last exactly one cycle; back-to-back grants to different FUs are permitted every cycle.
REQ-012 The same FU SHALL NOT be granted in two consecutive cycles.
REQ-013 flush high at an edge SHALL force CDB_result=0 and cdb_valid=0 and hold last.
- flush takes priority over any eligible request at that edge.
REQ-014 Any FU holding finish high SHALL be granted within NUM_FU cycles (no starvation).
REQ-015 finish bits that drop before being granted SHALL be ignored without error.

Reset
REQ-016 rst_n low SHALL immediately and asynchronously force all of the following; these are also the reset values of every output:
- CDB_result=0, cdb_valid=0, cdb_data=0, cdb_tag=0.
- last=NUM_FU-1, so index 0 has first priority.
REQ-017 Reset asserted mid-broadcast SHALL drop the grant in the same cycle.
- The first grant after reset release occurs at the first rising edge with rst_n high and a nonzero eligible set.

Structure
REQ-018 NUM_FU, DATA_W, TAG_W defaults and the FU index constants SHALL live in the shared core package.
- FU index constants: ALU=0 ... JUMP=5 ... up to 8.
REQ-019 The rotate-and-find-first logic SHALL be one sub-module, rr_pick, taking request vector and pointer and returning a one-hot grant plus a found flag.
REQ-020 Payload selection SHALL be an AND-OR of the one-hot grant; no priority-encoded mux chain.

Verification
REQ-021 Single request: finish[5]=1 at edge 1 with fu_data[5]=0x00001004, tag 3 -> cycle after edge 1 CDB_result=9'b000100000, cdb_data=0x00001004, cdb_tag=3. Edge 2: no regrant even though finish[5] is still high. finish[5] drops at edge 2 -> CDB_result=0 after edge 2.
REQ-022 All nine FUs request continuously after reset -> grants in order 0,1,...,8,0 over ten consecutive cycles.
REQ-023 finish[2] and finish[5] held high with last=3 -> FU5 granted first, FU2 granted next cycle.
REQ-024 flush=1 at the same edge as finish[0]=1 -> CDB_result stays 0 that cycle, last unchanged. FU0 is granted at the following edge.
REQ-025 rst_n pulled low mid-cycle while cdb_valid=1 -> all outputs 0 immediately, without a clock edge. After release, FU0 wins a tie against FU8.
REQ-026 Random finish traffic for 10k cycles -> checker confirms:
- one-hot or zero grant every cycle;
- no FU waits more than NUM_FU cycles;
- broadcast payload matches the granted FU's inputs.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared core constants for the common data bus arbiter.
// Default widths and functional-unit index assignments.
package cdb_arbiter_pkg;

    localparam int NUM_FU_D = 9;
    localparam int DATA_W_D = 32;
    localparam int TAG_W_D  = 5;

    localparam int FU_ALU  = 0;
    localparam int FU_ALU1 = 1;
    localparam int FU_MUL  = 2;
    localparam int FU_DIV  = 3;
    localparam int FU_LSU  = 4;
    localparam int FU_JUMP = 5;
    localparam int FU_FPU  = 6;
    localparam int FU_CSR  = 7;
    localparam int FU_MISC = 8;

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Round-robin rotate-and-find-first picker.
// Search starts just after the last winner and wraps.
module rr_pick #(
    parameter int N  = 9,
    parameter int PW = 4
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] last,
    output logic [N-1:0]  grant,
    output logic          found
);

    int            idx;
    logic [PW-1:0] pos;

    // Walk the ring from last+1; first requester takes the grant
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        pos   = '0;
        for (int off = 1; off <= N; off++) begin
            idx = int'(last) + off;
            if (idx >= N) idx = idx - N;
            pos = PW'(idx);
            if (!found && req[pos]) begin
                grant[pos] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one registered broadcast per cycle,
// round-robin among finished functional units.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_FU = NUM_FU_D,
    parameter int DATA_W = DATA_W_D,
    parameter int TAG_W  = TAG_W_D
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_FU-1:0]        finish,
    input  logic [NUM_FU*DATA_W-1:0] fu_data,
    input  logic [NUM_FU*TAG_W-1:0]  fu_tag,
    input  logic                     flush,
    output logic [NUM_FU-1:0]        CDB_result,
    output logic                     cdb_valid,
    output logic [DATA_W-1:0]        cdb_data,
    output logic [TAG_W-1:0]         cdb_tag
);

    localparam int PW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [PW-1:0]     last;
    logic [NUM_FU-1:0] elig;
    logic [NUM_FU-1:0] pick;
    logic              found;
    logic [DATA_W-1:0] sel_data;
    logic [TAG_W-1:0]  sel_tag;
    logic [PW-1:0]     sel_idx;

    // The FU holding the grant still shows finish for this cycle
    assign elig = finish & ~CDB_result;

    assign cdb_valid = |CDB_result;

    rr_pick #(
        .N  (NUM_FU),
        .PW (PW)
    ) u_pick (
        .req   (elig),
        .last  (last),
        .grant (pick),
        .found (found)
    );

    // AND-OR select of payload and winner index from the one-hot pick
    always_comb begin
        sel_data = '0;
        sel_tag  = '0;
        sel_idx  = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            sel_data |= fu_data[i*DATA_W +: DATA_W] & {DATA_W{pick[i]}};
            sel_tag  |= fu_tag[i*TAG_W +: TAG_W] & {TAG_W{pick[i]}};
            sel_idx  |= PW'(i) & {PW{pick[i]}};
        end
    end

    // Grant register, broadcast payload and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            CDB_result <= '0;
            cdb_data   <= '0;
            cdb_tag    <= '0;
            last       <= PW'(NUM_FU - 1);
        end else if (flush) begin
            CDB_result <= '0;
        end else if (found) begin
            CDB_result <= pick;
            cdb_data   <= sel_data;
            cdb_tag    <= sel_tag;
            last       <= sel_idx;
        end else begin
            CDB_result <= '0;
        end
    end

endmodule
